// File: rtl/grid_io_cfg_tile.sv
// -----------------------------------------------------------------------------
// grid_io_cfg_tile
//
// Configurable IO tile of NUM_SUBTILES pads. A serial configuration chain
// (3 bits per subtile) is shifted in on ccff_head. Once a full chain has been
// shifted and the enable drops, the chain is committed into a shadow register
// that drives the pad muxes. The pads never see the chain directly, so they
// keep running on the old configuration while a new one is being loaded.
//
// Ports
//   prog_clk     : clock, all state on rising edge
//   prog_reset   : synchronous active-high reset
//   ccff_en      : shift enable for the configuration chain
//   ccff_head    : serial configuration input
//   ccff_tail    : serial configuration output (registered chain end)
//   outpad       : fabric-to-pad data, one bit per subtile
//   oe_req       : fabric output-enable request (bidir mode only)
//   pad_in       : pad receive data
//   pad_out      : pad drive data
//   pad_oe       : pad drive enable, 1 = drive
//   inpad        : pad-to-fabric data
//   cfg_done     : shadow register holds a valid committed configuration
//   cfg_bit_cnt  : bits shifted since reset or restart, saturating at CHAIN_LEN
//
// Shadow layout for subtile k: shadow[3k+1:3k] = mode, shadow[3k+2] = rin.
//   mode 00 off, 01 input, 10 output, 11 bidir. rin=1 registers pad_in.
// -----------------------------------------------------------------------------
module grid_io_cfg_tile #(
  parameter int NUM_SUBTILES = 8,
  localparam int CFG_BITS  = 3,
  localparam int CHAIN_LEN = CFG_BITS * NUM_SUBTILES,
  localparam int CW        = $clog2(CHAIN_LEN + 1)
) (
  input  logic                    prog_clk,
  input  logic                    prog_reset,
  input  logic                    ccff_en,
  input  logic                    ccff_head,
  output logic                    ccff_tail,
  input  logic [NUM_SUBTILES-1:0] outpad,
  input  logic [NUM_SUBTILES-1:0] oe_req,
  input  logic [NUM_SUBTILES-1:0] pad_in,
  output logic [NUM_SUBTILES-1:0] pad_out,
  output logic [NUM_SUBTILES-1:0] pad_oe,
  output logic [NUM_SUBTILES-1:0] inpad,
  output logic                    cfg_done,
  output logic [CW-1:0]           cfg_bit_cnt
);

  localparam logic [CW-1:0] FULL_CNT = CW'(CHAIN_LEN);

  logic [CHAIN_LEN-1:0]    chain;
  logic [CHAIN_LEN-1:0]    shadow;
  logic [NUM_SUBTILES-1:0] in_reg;
  logic                    commit;

  // Commit happens once per full load, on the first idle edge after it.
  assign commit = !ccff_en && (cfg_bit_cnt == FULL_CNT) && !cfg_done;

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      chain       <= '0;
      shadow      <= '0;
      ccff_tail   <= 1'b0;
      cfg_bit_cnt <= '0;
      cfg_done    <= 1'b0;
      in_reg      <= '0;
    end else begin
      in_reg <= pad_in;
      if (ccff_en) begin
        chain     <= {chain[CHAIN_LEN-2:0], ccff_head};
        ccff_tail <= chain[CHAIN_LEN-1];
        if (cfg_done) begin
          // Restart: this shift is bit 1 of the new load; shadow is untouched.
          cfg_done    <= 1'b0;
          cfg_bit_cnt <= CW'(1);
        end else if (cfg_bit_cnt != FULL_CNT) begin
          cfg_bit_cnt <= cfg_bit_cnt + CW'(1);
        end
      end else if (commit) begin
        shadow   <= chain;
        cfg_done <= 1'b1;
      end
    end
  end

  // Pad muxes, driven only from the shadow register.
  always_comb begin
    pad_out = '0;
    pad_oe  = '0;
    inpad   = '0;
    for (int k = 0; k < NUM_SUBTILES; k++) begin
      logic [1:0] mode;
      logic       pin;
      mode = shadow[CFG_BITS*k +: 2];
      pin  = shadow[CFG_BITS*k + 2] ? in_reg[k] : pad_in[k];
      case (mode)
        2'b01: begin
          inpad[k] = pin;
        end
        2'b10: begin
          pad_oe[k]  = 1'b1;
          pad_out[k] = outpad[k];
        end
        2'b11: begin
          pad_oe[k]  = oe_req[k];
          pad_out[k] = outpad[k];
          inpad[k]   = pin;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_grid_io_cfg_tile.sv
// -----------------------------------------------------------------------------
// tb_grid_io_cfg_tile
//
// Bench for grid_io_cfg_tile with NUM_SUBTILES=8 (CHAIN_LEN=24). A reference
// model tracks the history of shifted bits, the bit count, the committed
// configuration word and the registered pad inputs, and derives expected pad
// behaviour from the mode table of each subtile.
// -----------------------------------------------------------------------------
module tb_grid_io_cfg_tile;

  localparam int N   = 8;
  localparam int LEN = 24;

  // Clock / reset block
  logic prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  logic         prog_reset = 1'b1;
  logic         ccff_en = 1'b0;
  logic         ccff_head = 1'b0;
  logic         ccff_tail;
  logic [N-1:0] outpad = '0;
  logic [N-1:0] oe_req = '0;
  logic [N-1:0] pad_in = '0;
  logic [N-1:0] pad_out;
  logic [N-1:0] pad_oe;
  logic [N-1:0] inpad;
  logic         cfg_done;
  logic [4:0]   cfg_bit_cnt;

  grid_io_cfg_tile #(.NUM_SUBTILES(N)) dut (
    .prog_clk    (prog_clk),
    .prog_reset  (prog_reset),
    .ccff_en     (ccff_en),
    .ccff_head   (ccff_head),
    .ccff_tail   (ccff_tail),
    .outpad      (outpad),
    .oe_req      (oe_req),
    .pad_in      (pad_in),
    .pad_out     (pad_out),
    .pad_oe      (pad_oe),
    .inpad       (inpad),
    .cfg_done    (cfg_done),
    .cfg_bit_cnt (cfg_bit_cnt)
  );

  int checks = 0;
  int errors = 0;
  bit rand_pads = 1'b1;

  // Reference model state
  bit           hist[$];      // bits shifted since reset, oldest first
  int           m_cnt;
  bit           m_done;
  bit           m_tail;
  logic [LEN-1:0] m_shadow;
  logic [N-1:0] m_in_reg;

  task automatic model_edge(input bit rst, input bit en, input bit hd);
    if (rst) begin
      hist.delete();
      m_cnt = 0; m_done = 0; m_tail = 0; m_shadow = '0; m_in_reg = '0;
    end else begin
      if (en) begin
        hist.push_back(hd);
        // A bit reaches the tail LEN+1 enabled shifts after it entered.
        m_tail = (hist.size() >= LEN + 1) ? hist[hist.size() - (LEN + 1)] : 1'b0;
        if (m_done) begin
          m_done = 0;
          m_cnt  = 1;
        end else if (m_cnt < LEN) begin
          m_cnt++;
        end
        if (hist.size() > LEN + 1) void'(hist.pop_front());
      end else if (m_cnt == LEN && !m_done) begin
        // Committed word: the last LEN bits, first of them in the top bit.
        for (int i = 0; i < LEN; i++)
          m_shadow[LEN-1-i] = hist[hist.size() - LEN + i];
        m_done = 1;
      end
      m_in_reg = pad_in;
    end
  endtask

  function automatic void exp_pads(output logic [N-1:0] e_oe, output logic [N-1:0] e_out,
                                   output logic [N-1:0] e_in);
    e_oe = '0; e_out = '0; e_in = '0;
    for (int k = 0; k < N; k++) begin
      logic [1:0] mode;
      logic       pin;
      mode = m_shadow[3*k +: 2];
      pin  = m_shadow[3*k+2] ? m_in_reg[k] : pad_in[k];
      if (mode == 2'd1) e_in[k] = pin;
      if (mode == 2'd2) begin e_oe[k] = 1'b1; e_out[k] = outpad[k]; end
      if (mode == 2'd3) begin e_oe[k] = oe_req[k]; e_out[k] = outpad[k]; e_in[k] = pin; end
    end
  endfunction

  // Driver: apply inputs away from the edge, clock once, advance the model.
  task automatic tick(input bit rst, input bit en, input bit hd);
    prog_reset = rst; ccff_en = en; ccff_head = hd;
    if (rand_pads) begin
      outpad = N'($urandom); oe_req = N'($urandom); pad_in = N'($urandom);
    end
    @(posedge prog_clk);
    model_edge(rst, en, hd);
    #1;
  endtask

  task automatic shift_word(input logic [LEN-1:0] w, input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b1, w[LEN-1-i]);
  endtask

  task automatic test_reset;
    tick(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    tick(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    checks++; if (pad_oe !== 8'h00) begin errors++; $display("FAIL reset_pad_oe got %h want 00", pad_oe); end
    checks++; if (pad_out !== 8'h00) begin errors++; $display("FAIL reset_pad_out got %h want 00", pad_out); end
    checks++; if (inpad !== 8'h00) begin errors++; $display("FAIL reset_inpad got %h want 00", inpad); end
    checks++; if (ccff_tail !== 1'b0) begin errors++; $display("FAIL reset_tail got %b want 0", ccff_tail); end
    checks++; if (cfg_bit_cnt !== 5'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", cfg_bit_cnt); end
    checks++; if (cfg_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", cfg_done); end
  endtask

  task automatic test_program_commit;
    logic [LEN-1:0] w;
    w = {{7{3'b001}}, 3'b010};
    tick(1'b1, 1'b0, 1'b0);
    shift_word(w, LEN);
    checks++; if (cfg_bit_cnt !== 5'd24) begin errors++; $display("FAIL commit_cnt got %0d want 24", cfg_bit_cnt); end
    checks++; if (cfg_done !== 1'b0) begin errors++; $display("FAIL commit_done_early got %b want 0", cfg_done); end
    tick(1'b0, 1'b0, 1'b0);
    checks++; if (cfg_done !== 1'b1) begin errors++; $display("FAIL commit_done got %b want 1", cfg_done); end
    for (int r = 0; r < 4; r++) begin
      outpad = N'($urandom); pad_in = N'($urandom); oe_req = N'($urandom);
      #1;
      checks++; if (pad_oe !== 8'h01) begin errors++; $display("FAIL commit_pad_oe got %h want 01", pad_oe); end
      checks++; if (pad_out !== {7'b0, outpad[0]}) begin errors++; $display("FAIL commit_pad_out got %h want %h", pad_out, {7'b0, outpad[0]}); end
      checks++; if (inpad !== {pad_in[7:1], 1'b0}) begin errors++; $display("FAIL commit_inpad got %h want %h", inpad, {pad_in[7:1], 1'b0}); end
    end
  endtask

  task automatic test_latency;
    tick(1'b1, 1'b0, 1'b0);
    for (int e = 1; e <= LEN + 1; e++) begin
      tick(1'b0, 1'b1, (e == 1));
      checks++;
      if (ccff_tail !== (e == LEN + 1)) begin
        errors++; $display("FAIL latency_tail edge %0d got %b want %b", e, ccff_tail, (e == LEN + 1));
      end
    end
    checks++; if (cfg_bit_cnt !== 5'd24) begin errors++; $display("FAIL latency_cnt got %0d want 24", cfg_bit_cnt); end
    tick(1'b0, 1'b1, 1'b0);
    checks++; if (cfg_bit_cnt !== 5'd24) begin errors++; $display("FAIL latency_cnt_sat got %0d want 24", cfg_bit_cnt); end
    checks++; if (ccff_tail !== 1'b0) begin errors++; $display("FAIL latency_tail_after got %b want 0", ccff_tail); end
  endtask

  task automatic test_registered_input;
    logic [LEN-1:0] w;
    logic           prev;
    w = '0;
    w[11:9]  = 3'b101;   // subtile 3: registered input
    w[17:15] = 3'b011;   // subtile 5: bidir, combinational input
    tick(1'b1, 1'b0, 1'b0);
    shift_word(w, LEN);
    tick(1'b0, 1'b0, 1'b0);
    checks++; if (cfg_done !== 1'b1) begin errors++; $display("FAIL rin_done got %b want 1", cfg_done); end
    rand_pads = 1'b0;
    for (int c = 0; c < 16; c++) begin
      prev = pad_in[3];
      tick(1'b0, 1'b0, 1'b0);
      checks++; if (inpad[3] !== prev) begin errors++; $display("FAIL rin_delay cycle %0d got %b want %b", c, inpad[3], prev); end
      pad_in[3] = ~pad_in[3];
      pad_in[5] = 1'($urandom_range(0, 1));
      oe_req[5] = ~oe_req[5];
      outpad    = N'($urandom);
      #1;
      checks++; if (inpad[3] !== prev) begin errors++; $display("FAIL rin_hold cycle %0d got %b want %b", c, inpad[3], prev); end
      checks++; if (pad_oe[5] !== oe_req[5]) begin errors++; $display("FAIL bidir_oe cycle %0d got %b want %b", c, pad_oe[5], oe_req[5]); end
      checks++; if (inpad[5] !== pad_in[5]) begin errors++; $display("FAIL bidir_in cycle %0d got %b want %b", c, inpad[5], pad_in[5]); end
      checks++; if (pad_out[5] !== outpad[5]) begin errors++; $display("FAIL bidir_out cycle %0d got %b want %b", c, pad_out[5], outpad[5]); end
    end
    rand_pads = 1'b1;
  endtask

  task automatic test_restart;
    logic [N-1:0] e_oe, e_out, e_in;
    // Entered with the configuration committed by the previous test.
    for (int i = 1; i <= 10; i++) begin
      tick(1'b0, 1'b1, 1'($urandom_range(0, 1)));
      checks++; if (cfg_done !== 1'b0) begin errors++; $display("FAIL restart_done shift %0d got %b want 0", i, cfg_done); end
      exp_pads(e_oe, e_out, e_in);
      checks++;
      if (pad_oe !== e_oe || pad_out !== e_out || inpad !== e_in) begin
        errors++; $display("FAIL restart_pads got %h/%h/%h want %h/%h/%h", pad_oe, pad_out, inpad, e_oe, e_out, e_in);
      end
    end
    checks++; if (cfg_bit_cnt !== 5'd10) begin errors++; $display("FAIL restart_cnt got %0d want 10", cfg_bit_cnt); end
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    checks++; if (cfg_done !== 1'b0) begin errors++; $display("FAIL restart_nocommit got %b want 0", cfg_done); end
    checks++; if (pad_oe[5] !== oe_req[5]) begin errors++; $display("FAIL restart_old_cfg got %b want %b", pad_oe[5], oe_req[5]); end
  endtask

  task automatic test_reset_mid_load;
    logic [LEN-1:0] w;
    logic [N-1:0]   e_oe, e_out, e_in;
    tick(1'b1, 1'b0, 1'b0);
    shift_word(LEN'($urandom), 12);
    checks++; if (cfg_bit_cnt !== 5'd12) begin errors++; $display("FAIL mid_cnt got %0d want 12", cfg_bit_cnt); end
    tick(1'b1, 1'b1, 1'b1);
    checks++; if (cfg_bit_cnt !== 5'd0 || cfg_done !== 1'b0 || ccff_tail !== 1'b0) begin
      errors++; $display("FAIL mid_reset got cnt %0d done %b tail %b want 0 0 0", cfg_bit_cnt, cfg_done, ccff_tail);
    end
    checks++; if (pad_oe !== 8'h00 || pad_out !== 8'h00 || inpad !== 8'h00) begin
      errors++; $display("FAIL mid_reset_pads got %h/%h/%h want 00/00/00", pad_oe, pad_out, inpad);
    end
    w = LEN'($urandom);
    shift_word(w, LEN);
    tick(1'b0, 1'b0, 1'b0);
    checks++; if (cfg_done !== 1'b1) begin errors++; $display("FAIL mid_full_commit got %b want 1", cfg_done); end
    checks++; if (m_shadow !== w) begin errors++; $display("FAIL mid_model_word got %h want %h", m_shadow, w); end
    exp_pads(e_oe, e_out, e_in);
    checks++;
    if (pad_oe !== e_oe || pad_out !== e_out || inpad !== e_in) begin
      errors++; $display("FAIL mid_full_pads got %h/%h/%h want %h/%h/%h", pad_oe, pad_out, inpad, e_oe, e_out, e_in);
    end
    tick(1'b1, 1'b0, 1'b0);
    shift_word(LEN'($urandom) | 24'h1, LEN - 1);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    checks++; if (cfg_done !== 1'b0) begin errors++; $display("FAIL mid_short_nocommit got %b want 0", cfg_done); end
    checks++; if (pad_oe !== 8'h00 || inpad !== 8'h00) begin errors++; $display("FAIL mid_short_pads got %h/%h want 00/00", pad_oe, inpad); end
  endtask

  task automatic test_random;
    logic [N-1:0] e_oe, e_out, e_in;
    bit rst, en;
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      en  = ($urandom_range(0, 9) < 7);
      tick(rst, en, 1'($urandom_range(0, 1)));
      exp_pads(e_oe, e_out, e_in);
      checks++;
      if (ccff_tail !== m_tail || cfg_bit_cnt !== 5'(m_cnt) || cfg_done !== m_done) begin
        errors++; $display("FAIL rand_state cycle %0d got tail %b cnt %0d done %b want %b %0d %b",
                           c, ccff_tail, cfg_bit_cnt, cfg_done, m_tail, m_cnt, m_done);
      end
      checks++;
      if (pad_oe !== e_oe || pad_out !== e_out || inpad !== e_in) begin
        errors++; $display("FAIL rand_pads cycle %0d got %h/%h/%h want %h/%h/%h", c, pad_oe, pad_out, inpad, e_oe, e_out, e_in);
      end
    end
  endtask

  initial begin
    test_reset;
    test_program_commit;
    test_latency;
    test_registered_input;
    test_restart;
    test_reset_mid_load;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/grid_io_cfg_tile.md
GRID_IO_CFG_TILE -- requirements
Module: grid_io_cfg_tile

Interface
REQ-001 Parameter NUM_SUBTILES, default 8, legal range 1..32: number of IO subtiles.
REQ-002 Derived constant CFG_BITS = 3: configuration bits per subtile. Derived constant CHAIN_LEN = 3*NUM_SUBTILES. Derived constant CW = clog2(CHAIN_LEN+1).
REQ-003 Port prog_clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-004 Port prog_reset, input, 1 bit: reset; synchronous, active-high.
REQ-005 Port ccff_en, input, 1 bit: configuration shift enable.
REQ-006 Port ccff_head, input, 1 bit: configuration serial data in.
REQ-007 Port ccff_tail, output, 1 bit: configuration serial data out, registered.
REQ-008 Port outpad, input, NUM_SUBTILES bits: fabric-to-pad data, one bit per subtile.
REQ-009 Port oe_req, input, NUM_SUBTILES bits: fabric output-enable request, used in bidir mode only.
REQ-010 Port pad_in, input, NUM_SUBTILES bits: pad receive data.
REQ-011 Port pad_out, output, NUM_SUBTILES bits: pad drive data.
REQ-012 Port pad_oe, output, NUM_SUBTILES bits: pad drive enable, 1 = drive.
REQ-013 Port inpad, output, NUM_SUBTILES bits: pad-to-fabric data.
REQ-014 Port cfg_done, output, 1 bit: active configuration valid.
REQ-015 Port cfg_bit_cnt, output, CW bits: count of bits shifted since reset or since restart.

Function
REQ-016 Internal shift chain is chain[CHAIN_LEN-1:0]. When ccff_en=1, each edge performs chain[0]<=ccff_head and chain[i]<=chain[i-1].
REQ-017 ccff_tail is the registered value of chain[CHAIN_LEN-1]. A bit entering at ccff_head appears on ccff_tail after CHAIN_LEN+1 enabled edges.
REQ-018 When ccff_en=0, the chain and ccff_tail hold their values.
REQ-019 cfg_bit_cnt behaviour:
- Increments by 1 per enabled shift.
- Saturates at CHAIN_LEN; shifting continues after saturation, so the last CHAIN_LEN bits win.
REQ-020 Commit: on the first edge with cfg_bit_cnt==CHAIN_LEN, ccff_en=0 and cfg_done=0:
- the shadow register is loaded with chain;
- cfg_done is set to 1.
REQ-021 If ccff_en is deasserted with cfg_bit_cnt<CHAIN_LEN, no commit occurs and cfg_done is unchanged.
REQ-022 Restart: an enabled shift while cfg_done=1:
- sets cfg_bit_cnt to 1;
- clears cfg_done on that edge;
- leaves the shadow register unchanged, so pads keep operating on the old configuration until the next commit.
REQ-023 Shadow field layout for subtile k is shadow[3k+2:3k]:
- bits [1:0] = mode;
- bit 2 = rin (registered input).
- The first bit shifted in after restart lands in subtile NUM_SUBTILES-1, bit 2.
REQ-024 Mode 00 (off): pad_oe[k]=0, pad_out[k]=0, inpad[k]=0.
REQ-025 Mode 01 (input): pad_oe[k]=0, pad_out[k]=0, inpad[k]=pin[k].
REQ-026 Mode 10 (output): pad_oe[k]=1, pad_out[k]=outpad[k], inpad[k]=0.
REQ-027 Mode 11 (bidir): pad_oe[k]=oe_req[k], pad_out[k]=outpad[k], inpad[k]=pin[k] (loopback allowed while driving).
REQ-028 pin[k] selection:
- rin=0: pin[k] = pad_in[k], combinational.
- rin=1: pin[k] = in_reg[k], where in_reg[k] <= pad_in[k] every edge (one-cycle latency).
REQ-029 pad_out, pad_oe and inpad are combinational from the shadow register, outpad, oe_req, pad_in and in_reg. There is no path from chain to pad outputs.

Reset
REQ-030 On an edge with prog_reset=1, the following clear to 0: chain, shadow, ccff_tail, cfg_bit_cnt, cfg_done, in_reg.
REQ-031 Reset takes priority over ccff_en and over commit.
REQ-032 After reset, all subtiles are in mode 00: pad_oe=0, pad_out=0, inpad=0.
REQ-033 Reset mid-shift discards the partial load; a full CHAIN_LEN-bit shift is required afterwards.

Verification (NUM_SUBTILES=8, CHAIN_LEN=24)
REQ-034 Reset scenario: assert prog_reset for 2 cycles with random inputs -> pad_oe=0x00, pad_out=0x00, inpad=0x00, ccff_tail=0, cfg_bit_cnt=0, cfg_done=0.
REQ-035 Program-and-commit scenario: shift 24 bits giving subtile0=010 (output, combinational) and subtiles 1..7=001 (input, combinational), then drop ccff_en.
- cfg_done=1 one edge later.
- pad_oe=0x01 (bit 0 set), pad_out[0] follows outpad[0] in the same cycle.
- inpad[7:1]=pad_in[7:1] in the same cycle; inpad[0]=0.
REQ-036 Latency scenario: shift a single 1 followed by zeros -> ccff_tail rises exactly after the 25th enabled edge; cfg_bit_cnt is 24 and held.
REQ-037 Registered-input scenario: subtile3=101 (registered input); toggle pad_in[3] each cycle -> inpad[3] equals pad_in[3] delayed by exactly 1 cycle. Bidir subtile with oe_req toggled -> pad_oe follows oe_req combinationally.
REQ-038 Restart scenario: with cfg_done=1, assert ccff_en for 10 shifts -> cfg_done=0 after the first edge, cfg_bit_cnt=10, pad outputs unchanged. Drop ccff_en -> no commit and cfg_done stays 0.
REQ-039 Reset-mid-load scenario: assert prog_reset at cfg_bit_cnt=12 -> all state 0. A subsequent 24-bit shift commits normally; a 23-bit shift does not commit.
